dmem_req_unit: RTL
==================

DMEM_REQ_UNIT -- requirements
Module: dmem_req_unit

Interface
REQ-001 The unit SHALL have parameter DATA_WIDTH_P, default 32, meaning the memory data width in bits (a multiple of 8, at least 16).
REQ-002 The unit SHALL have parameter ADDR_WIDTH_P, default data_mem_addr_width_gp (12), meaning the byte-address width.
REQ-003 The unit SHALL have parameter QUEUE_DEPTH_P, default 2, meaning the request FIFO entries (a power of two, at least 2).
REQ-004 The unit SHALL have parameter TIMEOUT_P, default 255, meaning the maximum cycles spent waiting on memory before error.
REQ-005 The unit SHALL have one clock and a synchronous, active-high reset; the ports SHALL be clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-006 The core-side request ports SHALL be: req_valid_i (input, 1, request offered); req_ready_o (output, 1, FIFO not full); req_wen_i (input, 1, store); req_byte_i (input, 1, byte access, for LBU/SB); req_addr_i (input, ADDR_WIDTH_P, byte address); req_data_i (input, DATA_WIDTH_P, store data).
REQ-007 The core-side response ports SHALL be: resp_valid_o (output, 1, one-cycle load-data pulse); resp_data_o (output, DATA_WIDTH_P, load result); idle_o (output, 1, FIFO empty and FSM idle); err_o (output, 1, sticky timeout error).
REQ-008 The memory request ports SHALL be: mem_valid_o, mem_wen_o and mem_byte_o (outputs, 1 each); mem_addr_o (output, ADDR_WIDTH_P); mem_wdata_o (output, DATA_WIDTH_P).
REQ-009 The memory handshake ports SHALL be: mem_yumi_i (input, 1, memory accepted request); mem_rvalid_i (input, 1, read data valid); mem_rdata_i (input, DATA_WIDTH_P, read data); mem_yumi_o (output, 1, core consumes read data).

Function
REQ-010 A request SHALL enqueue on a cycle where req_valid_i and req_ready_o are both high, and req_ready_o SHALL equal the FIFO not being full.
REQ-011 The FIFO SHALL preserve order, with read and write pointers wrapping modulo QUEUE_DEPTH_P.
REQ-012 Simultaneous enqueue and dequeue SHALL be legal whenever the FIFO is not full, and the count SHALL be unchanged on such a cycle.
REQ-013 The FSM SHALL have states DMEM_IDLE, DMEM_REQ_SENT, DMEM_REQ_ACKED and DMEM_ERR.
REQ-014 In DMEM_IDLE with the FIFO non-empty, the FSM SHALL go to DMEM_REQ_SENT on the next edge, so a request entered at cycle N drives mem_valid_o no earlier than N+1.
REQ-015 In DMEM_REQ_SENT, mem_valid_o SHALL be high and all mem_* request fields SHALL be driven from the FIFO head and held stable until mem_yumi_i is seen.
REQ-016 In DMEM_REQ_SENT with mem_yumi_i high, the FIFO head SHALL be popped; a store SHALL then return to DMEM_IDLE and a load SHALL go to DMEM_REQ_ACKED.
REQ-017 In DMEM_REQ_ACKED with mem_rvalid_i high, mem_yumi_o SHALL be asserted combinationally in the same cycle, resp_valid_o SHALL pulse on the next cycle with registered data, and the FSM SHALL return to DMEM_IDLE.
REQ-018 mem_rvalid_i SHALL be ignored outside DMEM_REQ_ACKED, and mem_yumi_o SHALL stay 0 in that case.
REQ-019 For a byte load, resp_data_o SHALL be the byte selected by addr[log2(DATA_WIDTH_P/8)-1:0] (little-endian lane order), zero-extended to DATA_WIDTH_P.
REQ-020 For a word load, resp_data_o SHALL equal mem_rdata_i.
REQ-021 For a byte store, mem_wdata_o SHALL carry req_data_i[7:0] replicated in every byte lane.
REQ-022 For a word store, mem_wdata_o SHALL carry req_data_i unchanged.
REQ-023 A wait counter SHALL clear on every entry to DMEM_REQ_SENT or DMEM_REQ_ACKED and SHALL increment each cycle spent in those states.
REQ-024 When the wait counter reaches TIMEOUT_P, the FSM SHALL go to DMEM_ERR, err_o SHALL go high, the FIFO SHALL be flushed and req_ready_o SHALL be held 0.
REQ-025 DMEM_ERR SHALL be left only by reset.
REQ-026 idle_o SHALL be high exactly when the FIFO is empty and the FSM is in DMEM_IDLE.
REQ-027 Back-to-back requests SHALL proceed without an idle bubble beyond REQ-014, giving at most one memory request per two cycles for stores.

Reset
REQ-028 While reset is high on a clock edge, the FSM SHALL go to DMEM_IDLE and the FIFO pointers, count and wait counter SHALL clear.
REQ-029 After reset, the outputs SHALL be: req_ready_o=1, resp_valid_o=0, resp_data_o=0, mem_valid_o=0, mem_yumi_o=0, idle_o=1, err_o=0.
REQ-030 A reset applied mid-transaction SHALL abandon the transaction, and the unit SHALL NOT issue mem_yumi_o for read data that arrives after the reset.

Structure
REQ-031 dmem_req_state_e (DMEM_IDLE, DMEM_REQ_SENT, DMEM_REQ_ACKED, DMEM_ERR) SHALL live in the definitions package, replacing the untyped dmem_req_state.
REQ-032 A packed struct dmem_req_s {wen, byte_not_word, addr, data} SHALL live in the definitions package.
REQ-033 The FIFO SHALL be a sub-module named dmem_req_fifo, parametrised by width and depth.
REQ-034 The lane select and byte replication logic SHALL stay in dmem_req_unit.

Verification
REQ-035 Word store then word load to 0x010, with memory yumi in 1 cycle and rvalid 2 cycles later returning 0xDEADBEEF: the bench SHALL see one resp_valid_o pulse with resp_data_o=0xDEADBEEF.
REQ-036 LBU at addr 0x013 with mem_rdata_i=0xAABBCCDD: the bench SHALL see resp_data_o=0x000000AA; SB of 0x5A: the bench SHALL see mem_wdata_o=0x5A5A5A5A and mem_byte_o=1.
REQ-037 With mem_yumi_i held 0 and 3 requests offered at QUEUE_DEPTH_P=2: the bench SHALL see req_ready_o=0 after 2 accepts, with no loss and in-order issue once yumi rises.
REQ-038 With mem_yumi_i stuck 0 and TIMEOUT_P=4: the bench SHALL see err_o=1 after 4 wait cycles, req_ready_o=0 and idle_o=0, with all of them cleared only by reset.
REQ-039 Reset asserted in DMEM_REQ_ACKED, then a late mem_rvalid_i: the bench SHALL see mem_yumi_o=0, resp_valid_o=0 and idle_o=1.
REQ-040 At DATA_WIDTH_P=64, LBU at lane 5: the bench SHALL see rdata[47:40] returned, zero-extended.

Source files
------------

// File: rtl/dmem_req_unit_pkg.sv
// Shared types for the data-memory request unit: FSM states and the queued request record.
package dmem_req_unit_pkg;

    localparam int data_mem_addr_width_gp = 12;

    // Widest supported fields; narrower instances zero-extend into the record.
    localparam int dmemAddrMaxW = 32;
    localparam int dmemDataMaxW = 128;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_REQ_SENT,
        DMEM_REQ_ACKED,
        DMEM_ERR
    } dmem_req_state_e;

    typedef struct packed {
        logic                    wen;
        logic                    byte_not_word;
        logic [dmemAddrMaxW-1:0] addr;
        logic [dmemDataMaxW-1:0] data;
    } dmem_req_s;

endpackage

// File: rtl/dmem_req_fifo.sv
// Order-preserving request queue with power-of-two depth and a synchronous flush.
module dmem_req_fifo #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               wValid,
    input  logic [WIDTH_P-1:0] wData,
    output logic               full,
    input  logic               rPop,
    output logic [WIDTH_P-1:0] rData,
    output logic               empty
);

    localparam int PtrW = $clog2(DEPTH_P);
    localparam logic [PtrW:0] FullCnt = DEPTH_P[PtrW:0];

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [PtrW-1:0]    wPtr;
    logic [PtrW-1:0]    rPtr;
    logic [PtrW:0]      count;
    logic               doWrite;
    logic               doRead;

    assign full    = (count == FullCnt);
    assign empty   = (count == '0);
    assign doWrite = wValid && !full;
    assign doRead  = rPop && !empty;
    assign rData   = mem[rPtr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wPtr  <= '0;
            rPtr  <= '0;
            count <= '0;
        end else begin
            if (doWrite) wPtr <= wPtr + PtrW'(1);
            if (doRead)  rPtr <= rPtr + PtrW'(1);
            case ({doWrite, doRead})
                2'b10:   count <= count + (PtrW+1)'(1);
                2'b01:   count <= count - (PtrW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) mem[wPtr] <= wData;
    end

endmodule

// File: rtl/dmem_req_unit.sv
// Core-to-data-memory request unit: queues loads/stores, sequences the memory
// handshake, formats byte accesses and flags a sticky timeout error.
module dmem_req_unit import dmem_req_unit_pkg::*; #(
    parameter int DATA_WIDTH_P  = 32,
    parameter int ADDR_WIDTH_P  = data_mem_addr_width_gp,
    parameter int QUEUE_DEPTH_P = 2,
    parameter int TIMEOUT_P     = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wen_i,
    input  logic                    req_byte_i,
    input  logic [ADDR_WIDTH_P-1:0] req_addr_i,
    input  logic [DATA_WIDTH_P-1:0] req_data_i,
    output logic                    resp_valid_o,
    output logic [DATA_WIDTH_P-1:0] resp_data_o,
    output logic                    idle_o,
    output logic                    err_o,
    output logic                    mem_valid_o,
    output logic                    mem_wen_o,
    output logic                    mem_byte_o,
    output logic [ADDR_WIDTH_P-1:0] mem_addr_o,
    output logic [DATA_WIDTH_P-1:0] mem_wdata_o,
    input  logic                    mem_yumi_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH_P-1:0] mem_rdata_i,
    output logic                    mem_yumi_o
);

    localparam int LaneCnt = DATA_WIDTH_P / 8;
    localparam int LaneW   = $clog2(LaneCnt);
    localparam int WaitW   = $clog2(TIMEOUT_P + 1);

    dmem_req_state_e state, nextState;
    dmem_req_s       enqReq, headReq;
    logic            fifoFull, fifoEmpty, fifoPop, fifoFlush;
    logic [WaitW-1:0] waitCnt;
    logic            waitExpired;
    logic            ldByte_p0;
    logic [LaneW-1:0] ldLane_p0;
    logic            respVld_p1;
    logic [DATA_WIDTH_P-1:0] respData_p1;
    logic            unusedHead;

    function automatic logic [DATA_WIDTH_P-1:0] replicateByte(input logic [7:0] b);
        return {LaneCnt{b}};
    endfunction

    function automatic logic [DATA_WIDTH_P-1:0] selectLane(input logic [DATA_WIDTH_P-1:0] word,
                                                           input logic [LaneW-1:0] lane);
        return DATA_WIDTH_P'(word[{lane, 3'b000} +: 8]);
    endfunction

    // Byte stores are replicated on the way into the queue so the head is memory-ready.
    always_comb begin
        enqReq               = '0;
        enqReq.wen           = req_wen_i;
        enqReq.byte_not_word = req_byte_i;
        enqReq.addr          = dmemAddrMaxW'(req_addr_i);
        enqReq.data          = dmemDataMaxW'(req_byte_i ? replicateByte(req_data_i[7:0]) : req_data_i);
    end

    dmem_req_fifo #(
        .WIDTH_P($bits(dmem_req_s)),
        .DEPTH_P(QUEUE_DEPTH_P)
    ) reqFifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifoFlush),
        .wValid(req_valid_i && req_ready_o),
        .wData (enqReq),
        .full  (fifoFull),
        .rPop  (fifoPop),
        .rData (headReq),
        .empty (fifoEmpty)
    );

    assign fifoFlush   = (state == DMEM_ERR);
    assign req_ready_o = !fifoFull && (state != DMEM_ERR);
    assign idle_o      = fifoEmpty && (state == DMEM_IDLE);
    assign err_o       = (state == DMEM_ERR);
    assign mem_wen_o   = headReq.wen;
    assign mem_byte_o  = headReq.byte_not_word;
    assign mem_addr_o  = headReq.addr[ADDR_WIDTH_P-1:0];
    assign mem_wdata_o = headReq.data[DATA_WIDTH_P-1:0];
    assign unusedHead  = ^headReq;
    assign waitExpired = (waitCnt == WaitW'(TIMEOUT_P - 1));
    assign resp_valid_o = respVld_p1;
    assign resp_data_o  = respData_p1;

    always_comb begin
        nextState   = state;
        fifoPop     = 1'b0;
        mem_valid_o = 1'b0;
        mem_yumi_o  = 1'b0;
        unique case (state)
            DMEM_IDLE: begin
                if (!fifoEmpty) nextState = DMEM_REQ_SENT;
            end
            DMEM_REQ_SENT: begin
                mem_valid_o = 1'b1;
                if (mem_yumi_i) begin
                    fifoPop   = 1'b1;
                    nextState = headReq.wen ? DMEM_IDLE : DMEM_REQ_ACKED;
                end else if (waitExpired) begin
                    nextState = DMEM_ERR;
                end
            end
            DMEM_REQ_ACKED: begin
                if (mem_rvalid_i) begin
                    mem_yumi_o = 1'b1;
                    nextState  = DMEM_IDLE;
                end else if (waitExpired) begin
                    nextState = DMEM_ERR;
                end
            end
            DMEM_ERR: nextState = DMEM_ERR;
        endcase
    end

    // Wait counter restarts on every state change and only runs while memory owes us something.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= DMEM_IDLE;
            waitCnt <= '0;
        end else begin
            state <= nextState;
            if (nextState != state)
                waitCnt <= '0;
            else if (state == DMEM_REQ_SENT || state == DMEM_REQ_ACKED)
                waitCnt <= waitCnt + WaitW'(1);
        end
    end

    // p0: remember how the popped load must be formatted
    always_ff @(posedge clk) begin
        if (fifoPop) begin
            ldByte_p0 <= headReq.byte_not_word;
            ldLane_p0 <= headReq.addr[LaneW-1:0];
        end
    end

    // p1: registered load response
    always_ff @(posedge clk) begin
        if (reset) begin
            respVld_p1  <= 1'b0;
            respData_p1 <= '0;
        end else begin
            respVld_p1 <= mem_yumi_o;
            if (mem_yumi_o)
                respData_p1 <= ldByte_p0 ? selectLane(mem_rdata_i, ldLane_p0) : mem_rdata_i;
        end
    end

endmodule
